// File: rtl/sfif_pkg.sv
// rtl/sfif_pkg.sv - shared SFIF TLP constants and completer state encoding.
package sfif_pkg;

  localparam logic [7:0] FT_MRD32 = 8'h00;
  localparam logic [7:0] FT_CPLD  = 8'h4A;
  localparam logic [7:0] FT_CPL   = 8'h0A;

  localparam logic [2:0] CPL_SC = 3'b000;
  localparam logic [2:0] CPL_UR = 3'b001;

  // Wide enough for buffer/beat indices of reads up to 16 dwords.
  localparam int IDX_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_FETCH,
    ST_SEND,
    ST_UR
  } cpl_state_e;

endpackage

// File: rtl/sfif_cpl_buf.sv
// rtl/sfif_cpl_buf.sv - completion payload buffer: sequential dword writes, 2-dword read port.
module sfif_cpl_buf
  import sfif_pkg::*;
#(
  parameter int MAX_DW = 8
) (
  input  logic             clk_125,
  input  logic             sfif_rstn,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [31:0]      wr_data,
  output logic [IDX_W-1:0] wr_idx,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_dw0,
  output logic [31:0]      rd_dw1
);

  logic [31:0]      mem [MAX_DW];
  logic [IDX_W-1:0] rd_idx1;

  always_ff @(posedge clk_125 or negedge sfif_rstn) begin
    if (!sfif_rstn) begin
      wr_idx <= '0;
    end else if (clr) begin
      wr_idx <= '0;
    end else if (wr_en) begin
      wr_idx <= wr_idx + IDX_W'(1);
    end
  end

  // Payload storage needs no reset; it is always written before being read.
  always_ff @(posedge clk_125) begin
    for (int i = 0; i < MAX_DW; i++) begin
      if (wr_en && (wr_idx == IDX_W'(i))) begin
        mem[i] <= wr_data;
      end
    end
  end

  assign rd_idx1 = rd_idx + IDX_W'(1);

  // Indices past the buffer read as zero so the odd tail dword is clean.
  always_comb begin
    rd_dw0 = '0;
    rd_dw1 = '0;
    for (int i = 0; i < MAX_DW; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_dw0 = mem[i];
      end
      if (rd_idx1 == IDX_W'(i)) begin
        rd_dw1 = mem[i];
      end
    end
  end

endmodule

// File: rtl/sfif_cpl_gen.sv
// rtl/sfif_cpl_gen.sv - MRd32 completer: decodes RX reads, fetches local dwords,
// returns a CplD or UR Cpl on the 64-bit TX stream, one request at a time.
module sfif_cpl_gen
  import sfif_pkg::*;
#(
  parameter int MAX_DW = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk_125,
  input  logic              sfif_rstn,
  input  logic              rx_st,
  input  logic              rx_end,
  input  logic [63:0]       rx_data,
  input  logic [15:0]       completer_id,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic              tx_val,
  input  logic              tx_rdy,
  output logic              tx_st,
  output logic              tx_end,
  output logic              tx_dwen,
  output logic [63:0]       tx_data,
  output logic              busy,
  output logic [15:0]       cpl_cnt,
  output logic [15:0]       drop_cnt
);

  cpl_state_e       state_q, state_d;
  logic [9:0]       len_q;
  logic [15:0]      req_id_q;
  logic [7:0]       tag_q;
  logic [31:0]      addr_q;
  logic [9:0]       rd_cnt_q;
  logic             cap_q;
  logic [IDX_W-1:0] beat_q;

  logic             is_mrd;
  logic             hdr_done;
  logic             len_bad;
  logic             tx_fire;
  logic             last_beat;
  logic [IDX_W-1:0] n_beats;
  logic [IDX_W-1:0] buf_wr_idx;
  logic [IDX_W-1:0] buf_rd_idx;
  logic [31:0]      dw0;
  logic [31:0]      dw1;
  logic             unused_bits;

  assign is_mrd   = rx_st && (rx_data[63:56] == FT_MRD32);
  assign hdr_done = (state_q == ST_HDR) && rx_end;
  assign len_bad  = (len_q == 10'd0) || (len_q > 10'(MAX_DW));
  assign n_beats  = IDX_W'((len_q + 10'd4) >> 1);
  assign busy     = (state_q != ST_IDLE);
  assign tx_fire  = tx_val && tx_rdy;

  assign rd_en   = (state_q == ST_FETCH) && (rd_cnt_q < len_q);
  assign rd_addr = rd_en ? (addr_q[ADDR_W+1:2] + ADDR_W'(rd_cnt_q)) : '0;

  // Beat 1 carries buf[0] in its low half; beat b>=2 carries buf[2b-3], buf[2b-2].
  assign buf_rd_idx = (beat_q < IDX_W'(2)) ? '0
                    : IDX_W'({beat_q, 1'b0} - (IDX_W + 1)'(3));

  assign unused_bits = ^{rx_data[7:0], addr_q[31:ADDR_W+2], addr_q[1:0]};

  sfif_cpl_buf #(
    .MAX_DW (MAX_DW)
  ) u_buf (
    .clk_125   (clk_125),
    .sfif_rstn (sfif_rstn),
    .clr       (hdr_done),
    .wr_en     (cap_q),
    .wr_data   (rd_data),
    .wr_idx    (buf_wr_idx),
    .rd_idx    (buf_rd_idx),
    .rd_dw0    (dw0),
    .rd_dw1    (dw1)
  );

  always_ff @(posedge clk_125 or negedge sfif_rstn) begin
    if (!sfif_rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tx_val    = 1'b0;
    tx_st     = 1'b0;
    tx_end    = 1'b0;
    tx_dwen   = 1'b0;
    tx_data   = '0;
    last_beat = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (is_mrd && !rx_end) begin
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (rx_end) begin
          state_d = len_bad ? ST_UR : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (cap_q && (buf_wr_idx == IDX_W'(len_q - 10'd1))) begin
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        tx_val    = 1'b1;
        last_beat = (beat_q == n_beats - IDX_W'(1));
        tx_st     = (beat_q == '0);
        tx_end    = last_beat;
        tx_dwen   = last_beat && !len_q[0];
        if (beat_q == '0) begin
          tx_data = {FT_CPLD, 14'd0, len_q, completer_id, CPL_SC, 1'b0, len_q, 2'b00};
        end else if (beat_q == IDX_W'(1)) begin
          tx_data = {req_id_q, tag_q, 1'b0, addr_q[6:2], 2'b00, dw0};
        end else begin
          tx_data = {dw0, tx_dwen ? 32'd0 : dw1};
        end
        if (tx_fire && last_beat) begin
          state_d = ST_IDLE;
        end
      end
      ST_UR: begin
        tx_val    = 1'b1;
        last_beat = (beat_q == IDX_W'(1));
        tx_st     = (beat_q == '0);
        tx_end    = last_beat;
        tx_dwen   = last_beat;
        tx_data   = last_beat ? {req_id_q, tag_q, 8'd0, 32'd0}
                              : {FT_CPL, 24'd0, completer_id, CPL_UR, 1'b0, 12'd4};
        if (tx_fire && last_beat) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_125 or negedge sfif_rstn) begin
    if (!sfif_rstn) begin
      len_q    <= '0;
      req_id_q <= '0;
      tag_q    <= '0;
      addr_q   <= '0;
      rd_cnt_q <= '0;
      cap_q    <= 1'b0;
      beat_q   <= '0;
      cpl_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if ((state_q == ST_IDLE) && is_mrd && !rx_end) begin
        len_q    <= rx_data[41:32];
        req_id_q <= rx_data[31:16];
        tag_q    <= rx_data[15:8];
      end
      if (hdr_done) begin
        addr_q   <= rx_data[63:32];
        rd_cnt_q <= '0;
      end else if (rd_en) begin
        rd_cnt_q <= rd_cnt_q + 10'd1;
      end
      // rd_data arrives one cycle after rd_en, so the capture strobe trails it.
      cap_q <= rd_en;
      if (tx_fire) begin
        beat_q <= last_beat ? '0 : beat_q + IDX_W'(1);
      end
      if (tx_fire && tx_end && (cpl_cnt != 16'hFFFF)) begin
        cpl_cnt <= cpl_cnt + 16'd1;
      end
      if (busy && is_mrd && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sfif_cpl_gen.sv
// tb/tb_sfif_cpl_gen.sv - directed bench for sfif_cpl_gen with a dword-stream completion model.
module tb_sfif_cpl_gen;

  localparam int MAX_DW = 8;
  localparam int ADDR_W = 8;

  logic        clk_125 = 1'b0;
  logic        sfif_rstn = 1'b1;
  logic        rx_st = 1'b0;
  logic        rx_end = 1'b0;
  logic [63:0] rx_data = '0;
  logic [15:0] completer_id = 16'h0100;
  logic        rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0] rd_data = '0;
  logic        tx_val;
  logic        tx_rdy = 1'b1;
  logic        tx_st, tx_end, tx_dwen;
  logic [63:0] tx_data;
  logic        busy;
  logic [15:0] cpl_cnt, drop_cnt;

  sfif_cpl_gen #(.MAX_DW(MAX_DW), .ADDR_W(ADDR_W)) dut (
    .clk_125(clk_125), .sfif_rstn(sfif_rstn), .rx_st(rx_st), .rx_end(rx_end),
    .rx_data(rx_data), .completer_id(completer_id), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .tx_val(tx_val), .tx_rdy(tx_rdy), .tx_st(tx_st), .tx_end(tx_end),
    .tx_dwen(tx_dwen), .tx_data(tx_data), .busy(busy), .cpl_cnt(cpl_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk_125 = ~clk_125;

  typedef struct packed {
    logic [63:0] d;
    logic        st;
    logic        en;
    logic        dw;
  } beat_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int t_end = 0;
  int first_val_cyc = 0;
  beat_t exp_tx[$];
  beat_t got_tx[$];
  logic [7:0] exp_rd[$];
  logic [7:0] got_rd[$];
  logic [31:0] mem [256];

  always @(posedge clk_125) cyc <= cyc + 1;
  always @(posedge clk_125) if (rd_en) rd_data <= mem[rd_addr];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Completion = header dwords followed by payload dwords, padded to whole 64-bit beats.
  task automatic model(input int len, input logic [31:0] addr, input logic [7:0] tag);
    logic [31:0] dw[$];
    logic [7:0]  a;
    beat_t       bt;
    bit          pad;
    int          nb;
    if (len == 0 || len > MAX_DW) begin
      bt.d = {8'h0A, 24'd0, completer_id, 3'b001, 1'b0, 12'd4}; bt.st = 1; bt.en = 0; bt.dw = 0;
      exp_tx.push_back(bt);
      bt.d = {16'h1234, tag, 8'd0, 32'd0}; bt.st = 0; bt.en = 1; bt.dw = 1;
      exp_tx.push_back(bt);
    end else begin
      dw.push_back({8'h4A, 14'd0, 10'(len)});
      dw.push_back({completer_id, 4'b0000, 12'(4 * len)});
      dw.push_back({16'h1234, tag, 1'b0, addr[6:2], 2'b00});
      for (int i = 0; i < len; i++) begin
        a = 8'((addr >> 2) + 32'(i));
        exp_rd.push_back(a);
        dw.push_back(mem[a]);
      end
      pad = (dw.size() % 2) == 1;
      if (pad) dw.push_back(32'd0);
      nb = dw.size() / 2;
      for (int b = 0; b < nb; b++) begin
        bt.d = {dw[2*b], dw[2*b+1]};
        bt.st = (b == 0);
        bt.en = (b == nb - 1);
        bt.dw = (b == nb - 1) && pad;
        exp_tx.push_back(bt);
      end
    end
  endtask

  initial begin : compare
    beat_t cur;
    beat_t held;
    logic  prev_stall;
    logic  prev_val;
    prev_stall = 0;
    prev_val = 0;
    held = '0;
    forever begin
      @(negedge clk_125);
      cur.d = tx_data; cur.st = tx_st; cur.en = tx_end; cur.dw = tx_dwen;
      if (rd_en) begin
        got_rd.push_back(rd_addr);
        if (exp_rd.size() == 0) begin
          tests++; fails++;
          $display("FAIL rd_unexpected: rd_addr %h while no read expected", rd_addr);
        end else begin
          check("rd_addr", 80'(rd_addr), 80'(exp_rd.pop_front()));
        end
      end
      if (tx_val && prev_stall) check("tx_hold", 80'(cur), 80'(held));
      if (tx_val && !prev_val) first_val_cyc = cyc;
      if (tx_val && tx_rdy) begin
        got_tx.push_back(cur);
        if (exp_tx.size() == 0) begin
          tests++; fails++;
          $display("FAIL tx_unexpected: beat %h while no beat expected", cur);
        end else begin
          check("tx_beat", 80'(cur), 80'(exp_tx.pop_front()));
        end
      end
      prev_stall = tx_val && !tx_rdy;
      prev_val = tx_val;
      held = cur;
    end
  end

  task automatic step();
    @(posedge clk_125);
    #1;
  endtask

  task automatic send_mrd(input int len, input logic [31:0] addr, input logic [7:0] tag,
                          input bit expect_cpl);
    if (expect_cpl) model(len, addr, tag);
    rx_st = 1; rx_data = {8'h00, 14'd0, 10'(len), 16'h1234, tag, 8'hFF};
    step();
    rx_st = 0; rx_end = 1; rx_data = {addr, 32'h0}; t_end = cyc;
    step();
    rx_end = 0; rx_data = '0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || exp_tx.size() != 0) && n < 200) begin
      step();
      n++;
    end
    check({name, "_done"}, 80'(n < 200), 80'(1));
    step();
  endtask

  task automatic wait_tx_val(input string name);
    int n = 0;
    while (!tx_val && n < 200) begin
      step();
      n++;
    end
    check({name, "_txval"}, 80'(tx_val), 80'(1));
  endtask

  task automatic check_zero(input string name);
    check({name, "_ctrl"}, 80'({tx_val, tx_st, tx_end, tx_dwen, rd_en, busy}), 80'(0));
    check({name, "_tx_data"}, 80'(tx_data), 80'(0));
    check({name, "_rd_addr"}, 80'(rd_addr), 80'(0));
    check({name, "_cnts"}, 80'({cpl_cnt, drop_cnt}), 80'(0));
  endtask

  task automatic clear_logs();
    got_tx.delete();
    got_rd.delete();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    for (int i = 0; i < 256; i++) mem[i] = {8'hA0, 8'(i), 8'h5A, 8'(~i)};
    mem[8'h40] = 32'hDEADBEEF;

    #1 sfif_rstn = 0;
    #1 check_zero("reset");
    repeat (3) step();
    sfif_rstn = 1;
    step();

    // len=1 at 0x100
    clear_logs();
    send_mrd(1, 32'h100, 8'h05, 1);
    wait_idle("t1");
    check("t1_rd_count", 80'(got_rd.size()), 80'(1));
    check("t1_rd_addr", 80'(got_rd[0]), 80'(8'h40));
    check("t1_beats", 80'(got_tx.size()), 80'(2));
    check("t1_beat0", 80'(got_tx[0].d), 80'h4A000001_01000004);
    check("t1_beat1", 80'(got_tx[1].d), 80'h12340500_DEADBEEF);
    check("t1_dwen", 80'(got_tx[1].dw), 80'(0));
    check("t1_latency", 80'(first_val_cyc - t_end), 80'(3));
    check("t1_cpl_cnt", 80'(cpl_cnt), 80'(1));

    // len=4 at 0x3F8: local address wraps
    clear_logs();
    send_mrd(4, 32'h3F8, 8'h22, 1);
    wait_idle("t2");
    check("t2_rd_count", 80'(got_rd.size()), 80'(4));
    check("t2_rd0", 80'(got_rd[0]), 80'(8'hFE));
    check("t2_rd1", 80'(got_rd[1]), 80'(8'hFF));
    check("t2_rd2", 80'(got_rd[2]), 80'(8'h00));
    check("t2_rd3", 80'(got_rd[3]), 80'(8'h01));
    check("t2_beats", 80'(got_tx.size()), 80'(4));
    check("t2_beat0", 80'(got_tx[0].d), 80'h4A000004_01000010);
    check("t2_last_dwen", 80'(got_tx[3].dw), 80'(1));
    check("t2_last_low", 80'(got_tx[3].d[31:0]), 80'(0));
    check("t2_latency", 80'(first_val_cyc - t_end), 80'(6));
    check("t2_cpl_cnt", 80'(cpl_cnt), 80'(2));

    // len=MAX_DW+1 and len=0 -> UR
    clear_logs();
    send_mrd(MAX_DW + 1, 32'h10, 8'h31, 1);
    wait_idle("ur9");
    check("ur9_no_rd", 80'(got_rd.size()), 80'(0));
    check("ur9_beats", 80'(got_tx.size()), 80'(2));
    check("ur9_beat0", 80'(got_tx[0].d), 80'h0A000000_01002004);
    check("ur9_beat1", 80'(got_tx[1].d), 80'h12343100_00000000);
    check("ur9_latency", 80'(first_val_cyc - t_end), 80'(1));
    clear_logs();
    send_mrd(0, 32'h10, 8'h32, 1);
    wait_idle("ur0");
    check("ur0_no_rd", 80'(got_rd.size()), 80'(0));
    check("ur0_beats", 80'(got_tx.size()), 80'(2));
    check("ur0_status", 80'(got_tx[0].d[15:13]), 80'(3'b001));
    check("ur0_cpl_cnt", 80'(cpl_cnt), 80'(4));

    // len=5 with tx_rdy 1-0-0-1
    clear_logs();
    send_mrd(5, 32'h40, 8'h44, 1);
    wait_tx_val("stall");
    step(); tx_rdy = 0;
    step();
    step(); tx_rdy = 1;
    wait_idle("stall");
    check("stall_beats", 80'(got_tx.size()), 80'(4));
    check("stall_last_dwen", 80'(got_tx[3].dw), 80'(0));
    check("stall_cpl_cnt", 80'(cpl_cnt), 80'(5));

    // second MRd32 during SEND is dropped
    clear_logs();
    send_mrd(4, 32'h80, 8'h55, 1);
    wait_tx_val("drop");
    send_mrd(2, 32'h90, 8'h56, 0);
    wait_idle("drop");
    repeat (6) step();
    check("drop_cnt", 80'(drop_cnt), 80'(1));
    check("drop_cpl_cnt", 80'(cpl_cnt), 80'(6));
    check("drop_beats", 80'(got_tx.size()), 80'(4));

    // MWr in IDLE is ignored
    clear_logs();
    rx_st = 1; rx_data = {8'h40, 14'd0, 10'd1, 16'h1234, 8'h57, 8'hFF};
    step();
    check("mwr_busy", 80'(busy), 80'(0));
    rx_st = 0; rx_end = 1; rx_data = {32'h0000_0200, 32'h1111_2222};
    step();
    rx_end = 0; rx_data = '0;
    repeat (4) step();
    check("mwr_cnts", 80'({cpl_cnt, drop_cnt}), 80'({16'd6, 16'd1}));
    check("mwr_no_traffic", 80'(got_rd.size() + got_tx.size()), 80'(0));

    // reset during beat 2 of a len=6 CplD
    clear_logs();
    send_mrd(6, 32'hC0, 8'h66, 1);
    wait_tx_val("rst");
    step();
    step();
    #1 sfif_rstn = 0;
    #1 check_zero("midrst");
    exp_tx.delete();
    exp_rd.delete();
    check("midrst_beats", 80'(got_tx.size()), 80'(2));
    step();
    sfif_rstn = 1;
    step();
    clear_logs();
    send_mrd(1, 32'h104, 8'h77, 1);
    wait_idle("post");
    check("post_beats", 80'(got_tx.size()), 80'(2));
    check("post_cnts", 80'({cpl_cnt, drop_cnt}), 80'({16'd1, 16'd0}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
